// File: rtl/output_deskewer_pkg.sv
// Array-wide defaults shared by the skew/deskew blocks, plus wavefront classification helpers.
package output_deskewer_pkg;

  localparam int unsigned SA_LANES      = 4;
  localparam int unsigned SA_DATA_WIDTH = 16;
  localparam int unsigned SA_ROWS       = 4;

  typedef enum logic [1:0] {
    WAVE_IDLE    = 2'd0,
    WAVE_ALIGNED = 2'd1,
    WAVE_BROKEN  = 2'd2
  } wave_e;

  // Low bit of lane i inside a packed lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic wave_e classify_wave(input logic all_valid, input logic any_valid);
    if (all_valid)      return WAVE_ALIGNED;
    else if (any_valid) return WAVE_BROKEN;
    else                return WAVE_IDLE;
  endfunction

endpackage

// File: rtl/output_deskewer_lane_delay.sv
// Enable-gated delay line; LENGTH=0 collapses to a plain wire.
module lane_delay #(
  parameter int unsigned LENGTH = 1,
  parameter int unsigned WIDTH  = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (LENGTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, enable};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [LENGTH];
      logic [WIDTH-1:0] stage_d [LENGTH];

      always_comb begin
        stage_d = stage_q;
        if (enable) begin
          stage_d[0] = din;
          for (int unsigned k = 1; k < LENGTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < LENGTH; k++) begin
            stage_q[k] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[LENGTH-1];
    end
  endgenerate

endmodule

// File: rtl/output_deskewer.sv
// Removes the per-lane stagger of the array's result wavefront and presents each row on one cycle,
// with row counting, last-row flag and broken-wavefront detection.
module output_deskewer
  import output_deskewer_pkg::*;
#(
  parameter int unsigned LANES      = SA_LANES,
  parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
  parameter int unsigned ROWS       = SA_ROWS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic [$clog2(ROWS):0]       row_idx,
  output logic                        align_err,
  output logic                        err_sticky
);

  localparam int unsigned RW = $clog2(ROWS) + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [LANES-1:0]            dly_valid;
  logic [LANES*DATA_WIDTH-1:0] dly_data;

  // Lane i is delayed so its word lines up with lane LANES-1, which arrives last.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DATA_WIDTH:0] lane_out;

      lane_delay #(
        .LENGTH(LANES - 1 - i),
        .WIDTH (DATA_WIDTH + 1)
      ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .din   ({in_valid[i], in_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]}),
        .dout  (lane_out)
      );

      assign dly_valid[i] = lane_out[DATA_WIDTH];
      assign dly_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = lane_out[DATA_WIDTH-1:0];
    end
  endgenerate

  wave_e wave;
  assign wave = classify_wave(&dly_valid, |dly_valid);

  logic                        out_valid_q,  out_valid_d;
  logic [LANES*DATA_WIDTH-1:0] out_data_q,   out_data_d;
  logic                        out_last_q,   out_last_d;
  logic [RW-1:0]               row_idx_q,    row_idx_d;
  logic [RW-1:0]               cnt_q,        cnt_d;
  logic                        align_err_q,  align_err_d;
  logic                        err_sticky_q, err_sticky_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    row_idx_d    = row_idx_q;
    cnt_d        = cnt_q;
    align_err_d  = align_err_q;
    err_sticky_d = err_sticky_q;

    if (enable) begin
      out_valid_d  = (wave == WAVE_ALIGNED);
      out_data_d   = dly_data;
      align_err_d  = (wave == WAVE_BROKEN);
      err_sticky_d = err_sticky_q | (wave == WAVE_BROKEN);
      out_last_d   = (wave == WAVE_ALIGNED) && (cnt_q == LAST_ROW);
      // row_idx keeps naming the last delivered row until a new aligned row loads.
      if (wave == WAVE_ALIGNED) begin
        row_idx_d = cnt_q;
        cnt_d     = (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      row_idx_q    <= '0;
      cnt_q        <= '0;
      align_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      row_idx_q    <= row_idx_d;
      cnt_q        <= cnt_d;
      align_err_q  <= align_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign row_idx    = row_idx_q;
  assign align_err  = align_err_q;
  assign err_sticky = err_sticky_q;

endmodule
